mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage RV32 pipeline; consumes the EX/MEM register driven by the Execution stage.
//  Holds word-addressed data RAM, resolves branch/jal/jalr, raises pipeline flush, and feeds the
//  forwarding path (mem_data). Registers MEM/WB outputs for the write-back mux.
// PARAMETERS
//  DMEM_WORDS  256  data RAM depth in 32-bit words (power of 2); index = ALUresult_in[log2(DMEM_WORDS)+1:2]
// PORTS
//  clk                 in   1   pipeline clock, rising edge
//  reset               in   1   synchronous, active-high
//  Ctl_MemtoReg_in     in   1   EX/MEM: write-back selects load data
//  Ctl_RegWrite_in     in   1   EX/MEM: instruction writes Rd
//  Ctl_MemRead_in      in   1   EX/MEM: load
//  Ctl_MemWrite_in     in   1   EX/MEM: store
//  Ctl_Branch_in       in   1   EX/MEM: conditional branch (beq/blt/bge/bne)
//  jal_in/jalr_in/bne_in in 1   EX/MEM: instruction class flags
//  Zero_in             in   1   EX/MEM: ALU zero flag
//  Rd_in               in   5   EX/MEM: destination register
//  ALUresult_in        in   32  EX/MEM: address / ALU result / jalr target
//  PCimm_in            in   32  EX/MEM: branch/jal target
//  ReadData2_in        in   32  EX/MEM: store data (already forwarded)
//  PC_in               in   32  EX/MEM: PC of this instruction
//  PCSrc_out           out  1   redirect fetch this cycle (combinational)
//  PCtarget_out        out  32  redirect target (combinational)
//  flush_out           out  1   kill IF/ID and ID/EX contents at next edge (== PCSrc_out)
//  mem_data_out        out  32  forwarding value for EX (ForwardA/B == 2'b10), combinational
//  Ctl_MemtoReg_out    out  1   MEM/WB registered
//  Ctl_RegWrite_out    out  1   MEM/WB registered
//  Rd_out              out  5   MEM/WB registered
//  ReadData_out        out  32  MEM/WB registered load data
//  ALUresult_out       out  32  MEM/WB registered result (link value for jal/jalr)
//  misalign_err        out  1   sticky: access with ALUresult_in[1:0] != 0
// BEHAVIOUR
//  Reset (sync, high): all MEM/WB outputs and misalign_err -> 0; RAM contents NOT cleared.
//  Reset dominates every other event in the same cycle (no RAM write, no err set).
//  Branch resolution (combinational on EX/MEM inputs):
//   taken = (Ctl_Branch_in & ~bne_in & Zero_in) | (Ctl_Branch_in & bne_in & ~Zero_in) | jal_in | jalr_in
//   PCtarget_out = jalr_in ? {ALUresult_in[31:1],1'b0} : PCimm_in; PCSrc_out = flush_out = taken & ~reset.
//   jalr has priority over jal if both flags set; target 0 when not taken is don't-care, drive PCimm_in.
//  Link: link = PC_in + 4; mem_data_out = (jal_in|jalr_in) ? link : ALUresult_in.
//  Alignment: mis = (Ctl_MemRead_in|Ctl_MemWrite_in) & (ALUresult_in[1:0] != 2'b00).
//   mis store: RAM write suppressed; mis load: ReadData_out <= 0; misalign_err set, held until reset.
//  RAM: word writes on clk edge when Ctl_MemWrite_in & ~mis & ~reset; address bits above index ignored (wrap).
//   Read asynchronous at same index; load in cycle N returns data written by any store before cycle N.
//  MEM/WB register (every edge, latency 1): Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out <= inputs;
//   ALUresult_out <= mem_data_out; ReadData_out <= Ctl_MemRead_in ? (mis ? 0 : RAM[idx]) : 0.
//  Rd_in == 0: passed through unchanged; register file ignores x0 writes.
//  Stage is never stalled or flushed itself: a taken branch still retires (jal/jalr link written back).
//  Simultaneous MemRead & MemWrite: illegal from decode; write happens, ReadData_out shows old word.
// TESTING
//  1 store 0x12345678 @addr 0x8, next cycle load 0x8 -> ReadData_out=0x12345678 one cycle after load.
//  2 Branch=1,bne=0,Zero=1,PCimm=0x40 -> PCSrc_out=1,flush_out=1,PCtarget_out=0x40; Zero=0 -> PCSrc_out=0.
//  3 bne=1,Branch=1,Zero=0 -> taken; jalr=1,ALUresult=0x1235,PC=0x100 -> target 0x1234, ALUresult_out=0x104.
//  4 store @0x6 -> RAM unchanged, misalign_err=1 and stays 1 through later legal ops until reset.
//  5 addr 0x408 with DMEM_WORDS=256 aliases addr 0x008 (wrap); ALU op Rd=5 -> Rd_out=5, ALUresult_out=ALUresult_in.
//  6 assert reset during a store with jal -> no write, PCSrc_out=0, all MEM/WB outputs 0 next cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RV32 pipeline: word-addressed data RAM, branch/jump
// resolution with fetch redirect, EX forwarding value and the MEM/WB register.
module mem_access_stage #(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Ctl_MemtoReg_in,
    input  logic        Ctl_RegWrite_in,
    input  logic        Ctl_MemRead_in,
    input  logic        Ctl_MemWrite_in,
    input  logic        Ctl_Branch_in,
    input  logic        jal_in,
    input  logic        jalr_in,
    input  logic        bne_in,
    input  logic        Zero_in,
    input  logic [4:0]  Rd_in,
    input  logic [31:0] ALUresult_in,
    input  logic [31:0] PCimm_in,
    input  logic [31:0] ReadData2_in,
    input  logic [31:0] PC_in,
    output logic        PCSrc_out,
    output logic [31:0] PCtarget_out,
    output logic        flush_out,
    output logic [31:0] mem_data_out,
    output logic        Ctl_MemtoReg_out,
    output logic        Ctl_RegWrite_out,
    output logic [4:0]  Rd_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUresult_out,
    output logic        misalign_err
);

    localparam int IDX_W = $clog2(DMEM_WORDS);

    logic [31:0]      dmem [0:DMEM_WORDS-1];
    logic [IDX_W-1:0] mem_idx;
    logic             mis;
    logic             taken;
    logic [31:0]      link;

    // Upper address bits beyond the RAM depth are ignored, so addresses wrap.
    assign mem_idx = ALUresult_in[IDX_W+1:2];
    assign mis     = (Ctl_MemRead_in | Ctl_MemWrite_in) & (ALUresult_in[1:0] != 2'b00);

    assign taken = (Ctl_Branch_in & ~bne_in & Zero_in)
                 | (Ctl_Branch_in &  bne_in & ~Zero_in)
                 | jal_in | jalr_in;

    assign PCSrc_out    = taken & ~reset;
    assign flush_out    = PCSrc_out;
    assign PCtarget_out = jalr_in ? {ALUresult_in[31:1], 1'b0} : PCimm_in;

    assign link         = PC_in + 32'd4;
    assign mem_data_out = (jal_in | jalr_in) ? link : ALUresult_in;

    // RAM contents survive reset; only the write is gated by it.
    always_ff @(posedge clk) begin
        if (!reset && Ctl_MemWrite_in && !mis) begin
            dmem[mem_idx] <= ReadData2_in;
        end
    end

    // Asynchronous read sees the pre-edge word, so a same-cycle store returns old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            Ctl_MemtoReg_out <= 1'b0;
            Ctl_RegWrite_out <= 1'b0;
            Rd_out           <= 5'd0;
            ReadData_out     <= 32'd0;
            ALUresult_out    <= 32'd0;
            misalign_err     <= 1'b0;
        end else begin
            Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
            Ctl_RegWrite_out <= Ctl_RegWrite_in;
            Rd_out           <= Rd_in;
            ALUresult_out    <= mem_data_out;
            ReadData_out     <= (Ctl_MemRead_in && !mis) ? dmem[mem_idx] : 32'd0;
            if (mis) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed-vector bench for mem_access_stage: combinational outputs checked at
// issue, MEM/WB outputs checked by a queue-driven monitor one edge later.
module tb_mem_access_stage;

    typedef struct {
        logic        rst, mtr, rw, mr, mw, br, jal, jalr, bne, zero;
        logic [4:0]  rd;
        logic [31:0] alu, pcimm, wdata, pc;
    } stim_t;

    typedef struct {
        logic        mtr, rw;
        logic [4:0]  rd;
        logic [31:0] rdata, alu;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in;
    logic        Ctl_Branch_in, jal_in, jalr_in, bne_in, Zero_in;
    logic [4:0]  Rd_in;
    logic [31:0] ALUresult_in, PCimm_in, ReadData2_in, PC_in;
    logic        PCSrc_out, flush_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, misalign_err;
    logic [31:0] PCtarget_out, mem_data_out, ReadData_out, ALUresult_out;
    logic [4:0]  Rd_out;

    int   checks   = 0;
    int   failures = 0;
    exp_t expq[$];
    exp_t mon_e;

    mem_access_stage #(.DMEM_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .Ctl_MemtoReg_in(Ctl_MemtoReg_in), .Ctl_RegWrite_in(Ctl_RegWrite_in),
        .Ctl_MemRead_in(Ctl_MemRead_in), .Ctl_MemWrite_in(Ctl_MemWrite_in),
        .Ctl_Branch_in(Ctl_Branch_in), .jal_in(jal_in), .jalr_in(jalr_in),
        .bne_in(bne_in), .Zero_in(Zero_in), .Rd_in(Rd_in),
        .ALUresult_in(ALUresult_in), .PCimm_in(PCimm_in),
        .ReadData2_in(ReadData2_in), .PC_in(PC_in),
        .PCSrc_out(PCSrc_out), .PCtarget_out(PCtarget_out), .flush_out(flush_out),
        .mem_data_out(mem_data_out), .Ctl_MemtoReg_out(Ctl_MemtoReg_out),
        .Ctl_RegWrite_out(Ctl_RegWrite_out), .Rd_out(Rd_out),
        .ReadData_out(ReadData_out), .ALUresult_out(ALUresult_out),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic exp_t ex(input logic mtr, input logic rw, input logic [4:0] rd,
                                input logic [31:0] rdata, input logic [31:0] alu, input logic err);
        exp_t e;
        e.mtr = mtr; e.rw = rw; e.rd = rd; e.rdata = rdata; e.alu = alu; e.err = err;
        return e;
    endfunction

    // Drive one EX/MEM word, check the combinational outputs, queue the MEM/WB result.
    task automatic applyStimulus(input string name, input stim_t s, input logic e_pcsrc,
                                 input logic [31:0] e_tgt, input logic [31:0] e_md, input exp_t e);
        @(negedge clk);
        reset           = s.rst;
        Ctl_MemtoReg_in = s.mtr;  Ctl_RegWrite_in = s.rw;
        Ctl_MemRead_in  = s.mr;   Ctl_MemWrite_in = s.mw;
        Ctl_Branch_in   = s.br;   jal_in = s.jal;  jalr_in = s.jalr;
        bne_in          = s.bne;  Zero_in = s.zero;
        Rd_in           = s.rd;   ALUresult_in = s.alu;
        PCimm_in        = s.pcimm; ReadData2_in = s.wdata; PC_in = s.pc;
        #1;
        checkOutput({name, ".PCSrc"},    {31'd0, PCSrc_out}, {31'd0, e_pcsrc});
        checkOutput({name, ".flush"},    {31'd0, flush_out}, {31'd0, e_pcsrc});
        checkOutput({name, ".PCtarget"}, PCtarget_out, e_tgt);
        checkOutput({name, ".mem_data"}, mem_data_out, e_md);
        expq.push_back(e);
    endtask

    // Monitor: every edge presents a new MEM/WB word, matched against the queue head.
    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            checkOutput("wb.MemtoReg", {31'd0, Ctl_MemtoReg_out}, {31'd0, mon_e.mtr});
            checkOutput("wb.RegWrite", {31'd0, Ctl_RegWrite_out}, {31'd0, mon_e.rw});
            checkOutput("wb.Rd",       {27'd0, Rd_out},           {27'd0, mon_e.rd});
            checkOutput("wb.ReadData", ReadData_out,              mon_e.rdata);
            checkOutput("wb.ALUresult", ALUresult_out,            mon_e.alu);
            checkOutput("wb.misalign", {31'd0, misalign_err},     {31'd0, mon_e.err});
        end
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        applyStimulus("rst0", s, 1'b0, 32'h0, 32'h0, ex(0, 0, 0, 0, 0, 0));
        applyStimulus("rst1", s, 1'b0, 32'h0, 32'h0, ex(0, 0, 0, 0, 0, 0));

        s = idle(); s.mw = 1; s.alu = 32'h8; s.wdata = 32'h12345678;
        applyStimulus("st8", s, 1'b0, 32'h0, 32'h8, ex(0, 0, 0, 0, 32'h8, 0));
        s = idle(); s.mr = 1; s.mtr = 1; s.rw = 1; s.rd = 5'd3; s.alu = 32'h8;
        applyStimulus("ld8", s, 1'b0, 32'h0, 32'h8, ex(1, 1, 3, 32'h12345678, 32'h8, 0));
        s = idle(); s.mr = 1; s.mtr = 1; s.rw = 1; s.rd = 5'd4; s.alu = 32'h408;
        applyStimulus("ld408", s, 1'b0, 32'h0, 32'h408, ex(1, 1, 4, 32'h12345678, 32'h408, 0));
        s = idle(); s.mw = 1; s.alu = 32'h408; s.wdata = 32'hCAFEF00D;
        applyStimulus("st408", s, 1'b0, 32'h0, 32'h408, ex(0, 0, 0, 0, 32'h408, 0));
        s = idle(); s.mr = 1; s.mtr = 1; s.rw = 1; s.rd = 5'd6; s.alu = 32'h8;
        applyStimulus("ld8b", s, 1'b0, 32'h0, 32'h8, ex(1, 1, 6, 32'hCAFEF00D, 32'h8, 0));
        s = idle(); s.rw = 1; s.rd = 5'd5; s.alu = 32'hDEADBEEF;
        applyStimulus("alu", s, 1'b0, 32'h0, 32'hDEADBEEF, ex(0, 1, 5, 0, 32'hDEADBEEF, 0));

        s = idle(); s.br = 1; s.zero = 1; s.pcimm = 32'h40;
        applyStimulus("beqT", s, 1'b1, 32'h40, 32'h0, ex(0, 0, 0, 0, 0, 0));
        s.zero = 0;
        applyStimulus("beqN", s, 1'b0, 32'h40, 32'h0, ex(0, 0, 0, 0, 0, 0));
        s = idle(); s.br = 1; s.bne = 1; s.pcimm = 32'h80;
        applyStimulus("bneT", s, 1'b1, 32'h80, 32'h0, ex(0, 0, 0, 0, 0, 0));
        s.zero = 1;
        applyStimulus("bneN", s, 1'b0, 32'h80, 32'h0, ex(0, 0, 0, 0, 0, 0));
        s = idle(); s.jal = 1; s.rw = 1; s.rd = 5'd1; s.pc = 32'h100; s.pcimm = 32'h200; s.alu = 32'h77;
        applyStimulus("jal", s, 1'b1, 32'h200, 32'h104, ex(0, 1, 1, 0, 32'h104, 0));
        s = idle(); s.jalr = 1; s.rw = 1; s.rd = 5'd1; s.pc = 32'h100; s.pcimm = 32'h999; s.alu = 32'h1235;
        applyStimulus("jalr", s, 1'b1, 32'h1234, 32'h104, ex(0, 1, 1, 0, 32'h104, 0));
        s.jal = 1; s.pc = 32'h200;
        applyStimulus("jaljalr", s, 1'b1, 32'h1234, 32'h204, ex(0, 1, 1, 0, 32'h204, 0));

        s = idle(); s.mr = 1; s.mw = 1; s.alu = 32'h8; s.wdata = 32'h11111111;
        applyStimulus("rdwr", s, 1'b0, 32'h0, 32'h8, ex(0, 0, 0, 32'hCAFEF00D, 32'h8, 0));
        s = idle(); s.mr = 1; s.alu = 32'h8;
        applyStimulus("ld8c", s, 1'b0, 32'h0, 32'h8, ex(0, 0, 0, 32'h11111111, 32'h8, 0));

        s = idle(); s.mw = 1; s.alu = 32'h4; s.wdata = 32'h44444444;
        applyStimulus("st4", s, 1'b0, 32'h0, 32'h4, ex(0, 0, 0, 0, 32'h4, 0));
        s = idle(); s.mw = 1; s.alu = 32'h6; s.wdata = 32'h00000BAD;
        applyStimulus("st6mis", s, 1'b0, 32'h0, 32'h6, ex(0, 0, 0, 0, 32'h6, 1));
        s = idle(); s.mr = 1; s.alu = 32'h4;
        applyStimulus("ld4", s, 1'b0, 32'h0, 32'h4, ex(0, 0, 0, 32'h44444444, 32'h4, 1));
        s = idle(); s.mr = 1; s.alu = 32'h9;
        applyStimulus("ld9mis", s, 1'b0, 32'h0, 32'h9, ex(0, 0, 0, 0, 32'h9, 1));
        s = idle(); s.rw = 1; s.rd = 5'd7; s.alu = 32'h3;
        applyStimulus("aluSticky", s, 1'b0, 32'h0, 32'h3, ex(0, 1, 7, 0, 32'h3, 1));

        s = idle(); s.rst = 1; s.mw = 1; s.jal = 1; s.rw = 1; s.mtr = 1; s.rd = 5'd9;
        s.alu = 32'h4; s.wdata = 32'h55555555; s.pc = 32'h100; s.pcimm = 32'h300;
        applyStimulus("rstStore", s, 1'b0, 32'h300, 32'h104, ex(0, 0, 0, 0, 0, 0));
        s = idle(); s.mr = 1; s.alu = 32'h4;
        applyStimulus("ld4post", s, 1'b0, 32'h0, 32'h4, ex(0, 0, 0, 32'h44444444, 32'h4, 0));

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
